pw_trigger_seq: RTL and testbench



---
 rtl/pw_trigger_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_pw_trigger_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pw_trigger_seq.sv
// Multi-pulse trigger sequencer: on a match edge, plays up to pNUM_TRIGGERS delay/width pulses on O_trigger.
// Optional one-shot arming is compiled in with PW_TRIGGER_SEQ_ONESHOT_EN.
module pw_trigger_seq #(
   parameter int pNUM_TRIGGERS        = 8,
   parameter int pTRIGGER_DELAY_WIDTH = 20,
   parameter int pTRIGGER_WIDTH_WIDTH = 17,
   parameter int pIDX_WIDTH           = 4
) (
   input  logic                                            trigger_clk,
   input  logic                                            reset_i,
   input  logic [pNUM_TRIGGERS*pTRIGGER_DELAY_WIDTH-1:0]   I_trigger_delay,
   input  logic [pNUM_TRIGGERS*pTRIGGER_WIDTH_WIDTH-1:0]   I_trigger_width,
   input  logic [pIDX_WIDTH-1:0]                           I_num_triggers,
   input  logic                                            I_match,
`ifdef PW_TRIGGER_SEQ_ONESHOT_EN
   input  logic                                            I_arm,
   output logic                                            O_armed,
`endif
   output logic                                            O_trigger,
   output logic                                            O_busy,
   output logic [pIDX_WIDTH-1:0]                           O_trigger_index,
   output logic                                            O_match_dropped
);

   localparam int DW = pTRIGGER_DELAY_WIDTH;
   localparam int WW = pTRIGGER_WIDTH_WIDTH;
   localparam int CW = (DW > WW) ? DW : WW;
   localparam logic [CW-1:0]         LP_CNT_ONE = CW'(1);
   localparam logic [pIDX_WIDTH-1:0] LP_IDX_ONE = pIDX_WIDTH'(1);
   localparam logic [pIDX_WIDTH-1:0] LP_N_MAX   = pIDX_WIDTH'(pNUM_TRIGGERS);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_PULSE = 2'd2
   } state_t;

   state_t                r_state;
   logic [pIDX_WIDTH-1:0] r_idx;
   logic [CW-1:0]         r_cnt;
   logic [pIDX_WIDTH-1:0] r_n;
   logic                  r_match_d;
   logic                  r_trigger;
   logic                  r_busy;
   logic [pIDX_WIDTH-1:0] r_trig_idx;
   logic                  r_dropped;

   state_t                w_nxt_state;
   logic [pIDX_WIDTH-1:0] w_nxt_idx;
   logic [CW-1:0]         w_nxt_cnt;
   logic [pIDX_WIDTH-1:0] w_nxt_n;
   logic                  w_launch;
   logic                  w_event;
   logic                  w_idle;
   logic                  w_armed;
   logic                  w_accept;
   logic [pIDX_WIDTH-1:0] w_n_eff;
   logic [pIDX_WIDTH-1:0] w_ls_start;
   logic [pIDX_WIDTH-1:0] w_ls_n;
   logic                  w_l_found;
   logic [pIDX_WIDTH-1:0] w_l_idx;
   logic [DW-1:0]         w_l_delay;
   logic [WW-1:0]         w_l_width;
   logic [WW-1:0]         w_cur_width;

   assign w_event   = I_match & ~r_match_d;
   assign w_idle    = (r_state == ST_IDLE);
   assign w_n_eff   = (I_num_triggers > LP_N_MAX) ? LP_N_MAX : I_num_triggers;
   assign w_accept  = w_event & w_idle & (w_n_eff != {pIDX_WIDTH{1'b0}}) & w_armed;
   assign w_l_delay   = I_trigger_delay[w_l_idx*DW +: DW];
   assign w_l_width   = I_trigger_width[w_l_idx*WW +: WW];
   assign w_cur_width = I_trigger_width[r_idx*WW +: WW];

`ifdef PW_TRIGGER_SEQ_ONESHOT_EN
   logic r_armed;
   logic r_arm_d;

   // Arm latch: set on an I_arm rising edge, consumed by the accepted event.
   always_ff @(posedge trigger_clk) begin
      if (reset_i) begin
         r_armed <= 1'b0;
         r_arm_d <= 1'b1;
      end else begin
         r_arm_d <= I_arm;
         if (w_accept) begin
            r_armed <= 1'b0;
         end else if (I_arm & ~r_arm_d) begin
            r_armed <= 1'b1;
         end else begin
            r_armed <= r_armed;
         end
      end
   end

   assign w_armed = r_armed;
   assign O_armed = r_armed;
`else
   assign w_armed = 1'b1;
`endif

   // Launch point: a new sequence starts at pulse 0, otherwise at the pulse after the current one.
   always_comb begin
      if (w_idle) begin
         w_ls_start = {pIDX_WIDTH{1'b0}};
         w_ls_n     = w_n_eff;
      end else begin
         w_ls_start = r_idx + LP_IDX_ONE;
         w_ls_n     = r_n;
      end
   end

   // First pulse at or after the launch point that consumes time; delay=0/width=0 pulses vanish.
   always_comb begin
      w_l_found = 1'b0;
      w_l_idx   = {pIDX_WIDTH{1'b0}};
      for (int j = pNUM_TRIGGERS - 1; j >= 0; j--) begin
         if ((j >= int'(w_ls_start)) && (j < int'(w_ls_n)) &&
             ((I_trigger_delay[j*DW +: DW] != {DW{1'b0}}) ||
              (I_trigger_width[j*WW +: WW] != {WW{1'b0}}))) begin
            w_l_found = 1'b1;
            w_l_idx   = pIDX_WIDTH'(j);
         end else begin
            w_l_found = w_l_found;
            w_l_idx   = w_l_idx;
         end
      end
   end

   // Next-state logic; the counter holds the cycles left in the current phase.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_idx   = r_idx;
      w_nxt_cnt   = r_cnt;
      w_nxt_n     = r_n;
      w_launch    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_launch = 1'b1;
               w_nxt_n  = w_n_eff;
            end else begin
               w_nxt_state = ST_IDLE;
            end
         end
         ST_DELAY: begin
            if (r_cnt == LP_CNT_ONE) begin
               if (w_cur_width != {WW{1'b0}}) begin
                  w_nxt_state = ST_PULSE;
                  w_nxt_cnt   = CW'(w_cur_width);
               end else begin
                  w_launch = 1'b1;
               end
            end else begin
               w_nxt_cnt = r_cnt - LP_CNT_ONE;
            end
         end
         ST_PULSE: begin
            if (r_cnt == LP_CNT_ONE) begin
               w_launch = 1'b1;
            end else begin
               w_nxt_cnt = r_cnt - LP_CNT_ONE;
            end
         end
         default: begin
            w_nxt_state = ST_IDLE;
            w_nxt_idx   = {pIDX_WIDTH{1'b0}};
            w_nxt_cnt   = {CW{1'b0}};
         end
      endcase
      if (w_launch) begin
         if (w_l_found) begin
            w_nxt_idx = w_l_idx;
            if (w_l_delay != {DW{1'b0}}) begin
               w_nxt_state = ST_DELAY;
               w_nxt_cnt   = CW'(w_l_delay);
            end else begin
               w_nxt_state = ST_PULSE;
               w_nxt_cnt   = CW'(w_l_width);
            end
         end else begin
            w_nxt_state = ST_IDLE;
            w_nxt_idx   = {pIDX_WIDTH{1'b0}};
            w_nxt_cnt   = {CW{1'b0}};
         end
      end else begin
         w_nxt_state = w_nxt_state;
      end
   end

   // State and output registers; outputs are taken from the next state so they line up with it.
   always_ff @(posedge trigger_clk) begin
      if (reset_i) begin
         r_state    <= ST_IDLE;
         r_idx      <= {pIDX_WIDTH{1'b0}};
         r_cnt      <= {CW{1'b0}};
         r_n        <= {pIDX_WIDTH{1'b0}};
         r_match_d  <= 1'b1;
         r_trigger  <= 1'b0;
         r_busy     <= 1'b0;
         r_trig_idx <= {pIDX_WIDTH{1'b0}};
         r_dropped  <= 1'b0;
      end else begin
         r_state    <= w_nxt_state;
         r_idx      <= w_nxt_idx;
         r_cnt      <= w_nxt_cnt;
         r_n        <= w_nxt_n;
         r_match_d  <= I_match;
         r_trigger  <= (w_nxt_state == ST_PULSE);
         r_busy     <= (w_nxt_state != ST_IDLE);
         r_trig_idx <= w_nxt_idx;
         r_dropped  <= w_event & ~w_idle;
      end
   end

   assign O_trigger       = r_trigger;
   assign O_busy          = r_busy;
   assign O_trigger_index = r_trig_idx;
   assign O_match_dropped = r_dropped;

endmodule

// File: tb/tb_pw_trigger_seq.sv
// Scoreboard bench for pw_trigger_seq: a timing-formula model fills expected traces per scenario.
module tb_pw_trigger_seq;

   localparam int NT   = 8;
   localparam int DW   = 20;
   localparam int WW   = 17;
   localparam int IW   = 4;
   localparam int LMAX = 400;

   logic              clk = 1'b0;
   logic              rst;
   logic [NT*DW-1:0]  cfg_delay;
   logic [NT*WW-1:0]  cfg_width;
   logic [IW-1:0]     cfg_num;
   logic              match;
   logic              arm;
   logic              o_trig;
   logic              o_busy;
   logic [IW-1:0]     o_idx;
   logic              o_drop;
   logic              o_armed;

   always #5 clk = ~clk;

   pw_trigger_seq #(
      .pNUM_TRIGGERS(NT), .pTRIGGER_DELAY_WIDTH(DW),
      .pTRIGGER_WIDTH_WIDTH(WW), .pIDX_WIDTH(IW)
   ) dut (
      .trigger_clk     (clk),
      .reset_i         (rst),
      .I_trigger_delay (cfg_delay),
      .I_trigger_width (cfg_width),
      .I_num_triggers  (cfg_num),
      .I_match         (match),
`ifdef PW_TRIGGER_SEQ_ONESHOT_EN
      .I_arm           (arm),
      .O_armed         (o_armed),
`endif
      .O_trigger       (o_trig),
      .O_busy          (o_busy),
      .O_trigger_index (o_idx),
      .O_match_dropped (o_drop)
   );

`ifndef PW_TRIGGER_SEQ_ONESHOT_EN
   assign o_armed = 1'b0;
`endif

   typedef struct packed {
      logic          trig;
      logic          busy;
      logic [IW-1:0] idx;
      logic          drop;
      logic          armed;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   bit   m_w [LMAX];
   bit   r_w [LMAX];
   bit   a_w [LMAX];
   bit   mdl_prev  = 1'b1;
   bit   mdl_aprev = 1'b1;
   bit   mdl_armed = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_stim();
      for (int i = 0; i < LMAX; i++) begin
         m_w[i] = 1'b0;
         r_w[i] = 1'b0;
         a_w[i] = 1'b0;
      end
   endtask

   task automatic set_match(input int from, input int to);
      for (int i = from; i <= to; i++) m_w[i] = 1'b1;
   endtask

   task automatic set_cfg(input int i, input int d, input int w);
      logic [31:0] dv;
      logic [31:0] wv;
      dv = d;
      wv = w;
      cfg_delay[i*DW +: DW] = dv[DW-1:0];
      cfg_width[i*WW +: WW] = wv[WW-1:0];
   endtask

   task automatic run_scn(input string name, input int len);
      bit   et [LMAX+1];
      bit   eb [LMAX+1];
      bit   ed [LMAX+1];
      bit   ea [LMAX+1];
      int   ei [LMAX+1];
      int   n_eff;
      int   t;
      int   st;
      bit   ev;
      bit   aedge;
      bit   acc;
      bit   armed_eff;
      exp_t e;

      n_eff = (int'(cfg_num) > NT) ? NT : int'(cfg_num);
      for (int k = 0; k <= LMAX; k++) begin
         et[k] = 1'b0; eb[k] = 1'b0; ed[k] = 1'b0; ea[k] = 1'b0; ei[k] = 0;
      end
      ea[0] = mdl_armed;

      // Expected trace from the pulse timing formula.
      for (int c = 0; c < len; c++) begin
         if (r_w[c]) begin
            for (int k = c + 1; k <= len; k++) begin
               et[k] = 1'b0; eb[k] = 1'b0; ed[k] = 1'b0; ei[k] = 0;
            end
            ea[c+1]   = 1'b0;
            mdl_prev  = 1'b1;
            mdl_aprev = 1'b1;
         end else begin
            ev       = m_w[c] && !mdl_prev;
            mdl_prev = m_w[c];
`ifdef PW_TRIGGER_SEQ_ONESHOT_EN
            armed_eff = ea[c];
`else
            armed_eff = 1'b1;
`endif
            acc = 1'b0;
            if (ev) begin
               if (eb[c]) begin
                  ed[c+1] = 1'b1;
               end else if (n_eff > 0 && armed_eff) begin
                  acc = 1'b1;
                  t = c + 1;
                  for (int i = 0; i < n_eff; i++) begin
                     st = t + int'(cfg_delay[i*DW +: DW]);
                     for (int k = t; k < st + int'(cfg_width[i*WW +: WW]) && k <= len; k++) begin
                        eb[k] = 1'b1;
                        ei[k] = i;
                        if (k >= st) et[k] = 1'b1;
                     end
                     t = st + int'(cfg_width[i*WW +: WW]);
                  end
               end
            end
            aedge     = a_w[c] && !mdl_aprev;
            mdl_aprev = a_w[c];
            ea[c+1]   = acc ? 1'b0 : (aedge ? 1'b1 : ea[c]);
         end
      end
      mdl_armed = ea[len];

      e = '{trig: et[0], busy: eb[0], idx: ei[0][IW-1:0], drop: ed[0], armed: ea[0]};
      exp_q.push_back(e);
      for (int c = 0; c < len; c++) begin
         @(posedge clk);
         #1;
         rst   = r_w[c];
         match = m_w[c];
         arm   = a_w[c];
         e = '{trig: et[c+1], busy: eb[c+1], idx: ei[c+1][IW-1:0], drop: ed[c+1], armed: ea[c+1]};
         exp_q.push_back(e);
         @(negedge clk);
         e = exp_q.pop_front();
         check_val($sformatf("%s.trig@%0d", name, c), o_trig, e.trig);
         check_val($sformatf("%s.busy@%0d", name, c), o_busy, e.busy);
         check_val($sformatf("%s.idx@%0d", name, c), o_idx, e.idx);
         check_val($sformatf("%s.drop@%0d", name, c), o_drop, e.drop);
`ifdef PW_TRIGGER_SEQ_ONESHOT_EN
         check_val($sformatf("%s.armed@%0d", name, c), o_armed, e.armed);
`endif
      end
      exp_q.delete();
   endtask

   initial begin
      rst       = 1'b1;
      match     = 1'b0;
      arm       = 1'b0;
      cfg_delay = {(NT*DW){1'b0}};
      cfg_width = {(NT*WW){1'b0}};
      cfg_num   = {IW{1'b0}};
      repeat (3) @(posedge clk);
      #1;

      clear_stim();
      run_scn("reset_idle", 4);

      cfg_num = 4'd1; set_cfg(0, 5, 3);
      clear_stim(); set_match(10, 12);
      run_scn("basic", 30);

      cfg_num = 4'd3; set_cfg(0, 2, 1); set_cfg(1, 4, 2); set_cfg(2, 0, 3);
      clear_stim(); set_match(0, 1);
      run_scn("three", 20);

      cfg_num = 4'd2; set_cfg(0, 1, 0); set_cfg(1, 1, 2);
      clear_stim(); set_match(0, 0);
      run_scn("zero_w", 10);

      cfg_num = 4'd1; set_cfg(0, 3, 6);
      clear_stim(); set_match(0, 1); set_match(5, 7); set_match(9, 10);
      run_scn("drop", 20);

      cfg_num = 4'd0;
      clear_stim(); set_match(2, 3); set_match(6, 6);
      run_scn("n_zero", 12);

      cfg_num = 4'd15;
      set_cfg(0, 1, 1); set_cfg(1, 0, 0); set_cfg(2, 0, 2); set_cfg(3, 2, 0);
      set_cfg(4, 1, 1); set_cfg(5, 0, 0); set_cfg(6, 0, 0); set_cfg(7, 3, 2);
      clear_stim(); set_match(1, 2);
      run_scn("clamp", 30);

      cfg_num = 4'd2;
      clear_stim(); set_match(1, 1);
      run_scn("tail_skip", 8);

      cfg_num = 4'd1; set_cfg(0, 2, 100);
      clear_stim(); set_match(0, 60); set_match(70, 71); r_w[30] = 1'b1;
      run_scn("rst_mid", 180);

`ifdef PW_TRIGGER_SEQ_ONESHOT_EN
      cfg_num = 4'd1; set_cfg(0, 1, 2);
      clear_stim(); set_match(1, 2); set_match(5, 5);
      run_scn("noarm", 12);

      clear_stim(); a_w[1] = 1'b1; a_w[2] = 1'b1;
      set_match(4, 4); set_match(6, 6); set_match(10, 10);
      run_scn("arm", 16);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
